// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe_reg
// Description : ID/EX pipeline register built as a two-entry skid buffer.
//               A main entry drives the outputs and a skid entry absorbs one
//               extra payload so that in_ready is a pure register output.
//               A bubble (out_valid low) presents an all-zero control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipe_reg #(
   parameter int DATA_W  = 64,
   parameter int REG_W   = 5,
   parameter int CTRL_W  = 8,
   parameter int FUNCT_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   // upstream handshake and payload
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [CTRL_W-1:0]  in_ctrl,
   input  logic [FUNCT_W-1:0] in_funct,
   input  logic [REG_W-1:0]   in_rs1,
   input  logic [REG_W-1:0]   in_rs2,
   input  logic [REG_W-1:0]   in_rd,
   input  logic [DATA_W-1:0]  in_imm,
   input  logic [DATA_W-1:0]  in_rd1,
   input  logic [DATA_W-1:0]  in_rd2,
   input  logic [DATA_W-1:0]  in_pc,
   // downstream handshake and payload
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CTRL_W-1:0]  out_ctrl,
   output logic [FUNCT_W-1:0] out_funct,
   output logic [REG_W-1:0]   out_rs1,
   output logic [REG_W-1:0]   out_rs2,
   output logic [REG_W-1:0]   out_rd,
   output logic [DATA_W-1:0]  out_imm,
   output logic [DATA_W-1:0]  out_rd1,
   output logic [DATA_W-1:0]  out_rd2,
   output logic [DATA_W-1:0]  out_pc,
   output logic [1:0]         occupancy
);

   // All payload fields travel together as one packed word.
   localparam int PAY_W = CTRL_W + FUNCT_W + 3 * REG_W + 4 * DATA_W;

   // State encoding equals the number of valid entries held.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic               in_ready_q;
   logic [PAY_W-1:0]   main_q;
   logic [PAY_W-1:0]   skid_q;
   logic [PAY_W-1:0]   payload_in;
   logic [CTRL_W-1:0]  main_ctrl;
   logic               push;
   logic               pop;
   logic               load_main_in;
   logic               load_main_skid;
   logic               load_skid;

   assign payload_in = {in_ctrl, in_funct, in_rs1, in_rs2, in_rd,
                        in_imm, in_rd1, in_rd2, in_pc};

   assign {main_ctrl, out_funct, out_rs1, out_rs2, out_rd,
           out_imm, out_rd1, out_rd2, out_pc} = main_q;

   assign out_valid = (state_q != EMPTY);
   // Bubbles must look like a NOP downstream, so the control bundle is gated.
   assign out_ctrl  = out_valid ? main_ctrl : '0;
   assign occupancy = state_q;
   assign in_ready  = in_ready_q;

   assign push = in_valid & in_ready_q;
   assign pop  = out_valid & out_ready;

   // Next-state and load-enable decode; flush overrides every transfer.
   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
         EMPTY: begin
            if (push) begin
               state_d      = ONE;
               load_main_in = 1'b1;
            end
         end
         ONE: begin
            if (push && pop) begin
               load_main_in = 1'b1;
            end else if (push) begin
               state_d   = TWO;
               load_skid = 1'b1;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            // in_ready is low here, so only a drain can happen.
            if (pop) begin
               state_d        = ONE;
               load_main_skid = 1'b1;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
      if (flush) begin
         state_d        = EMPTY;
         load_main_in   = 1'b0;
         load_main_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   // State register; in_ready is registered from the next state so it never
   // depends combinationally on out_ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != TWO);
      end
   end

   // Payload storage; fields keep their last value when not reloaded.
   always_ff @(posedge clk) begin
      if (reset) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in) begin
            main_q <= payload_in;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= payload_in;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_pipe_reg
// Description : Bench for id_ex_pipe_reg. Drives a default-width instance and
//               a DATA_W=32/REG_W=6 instance with the same handshakes, checks
//               directed vectors and a random stream against a FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe_reg;

   typedef struct packed {
      logic [7:0]  ctrl;
      logic [3:0]  funct;
      logic [5:0]  rs1;
      logic [5:0]  rs2;
      logic [5:0]  rd;
      logic [63:0] imm;
      logic [63:0] rd1;
      logic [63:0] rd2;
      logic [63:0] pc;
   } pay_t;

   typedef struct {
      bit          rst;
      bit          fl;
      bit          iv;
      bit          ordy;
      logic [63:0] pc;
      logic [7:0]  ctrl;
      int          eocc;
      bit          eov;
      bit          eir;
      logic [63:0] epc;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset    = 1'b0;
   logic flush    = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   pay_t in_p = '0;

   // default-width instance
   logic        a_in_ready, a_out_valid;
   logic [7:0]  a_ctrl;
   logic [3:0]  a_funct;
   logic [4:0]  a_rs1, a_rs2, a_rd;
   logic [63:0] a_imm, a_rd1, a_rd2, a_pc;
   logic [1:0]  a_occ;

   // narrow instance
   logic        b_in_ready, b_out_valid;
   logic [7:0]  b_ctrl;
   logic [3:0]  b_funct;
   logic [5:0]  b_rs1, b_rs2, b_rd;
   logic [31:0] b_imm, b_rd1, b_rd2, b_pc;
   logic [1:0]  b_occ;

   id_ex_pipe_reg dut_a (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(a_in_ready),
      .in_ctrl(in_p.ctrl), .in_funct(in_p.funct),
      .in_rs1(in_p.rs1[4:0]), .in_rs2(in_p.rs2[4:0]), .in_rd(in_p.rd[4:0]),
      .in_imm(in_p.imm), .in_rd1(in_p.rd1), .in_rd2(in_p.rd2), .in_pc(in_p.pc),
      .out_valid(a_out_valid), .out_ready(out_ready),
      .out_ctrl(a_ctrl), .out_funct(a_funct),
      .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd),
      .out_imm(a_imm), .out_rd1(a_rd1), .out_rd2(a_rd2), .out_pc(a_pc),
      .occupancy(a_occ)
   );

   id_ex_pipe_reg #(.DATA_W(32), .REG_W(6)) dut_b (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready),
      .in_ctrl(in_p.ctrl), .in_funct(in_p.funct),
      .in_rs1(in_p.rs1), .in_rs2(in_p.rs2), .in_rd(in_p.rd),
      .in_imm(in_p.imm[31:0]), .in_rd1(in_p.rd1[31:0]),
      .in_rd2(in_p.rd2[31:0]), .in_pc(in_p.pc[31:0]),
      .out_valid(b_out_valid), .out_ready(out_ready),
      .out_ctrl(b_ctrl), .out_funct(b_funct),
      .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd),
      .out_imm(b_imm), .out_rd1(b_rd1), .out_rd2(b_rd2), .out_pc(b_pc),
      .occupancy(b_occ)
   );

   int   tests  = 0;
   int   failed = 0;
   pay_t q[$];
   pay_t last = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic pay_t rand_pay();
      pay_t p;
      p.ctrl  = 8'($urandom);
      p.funct = 4'($urandom);
      p.rs1   = 6'($urandom);
      p.rs2   = 6'($urandom);
      p.rd    = 6'($urandom);
      p.imm   = {$urandom, $urandom};
      p.rd1   = {$urandom, $urandom};
      p.rd2   = {$urandom, $urandom};
      p.pc    = {$urandom, $urandom};
      return p;
   endfunction

   // Compare both instances against the model head (or held last value).
   task automatic check_outputs();
      logic       v;
      logic [7:0] ec;
      v  = (q.size() > 0);
      ec = v ? last.ctrl : 8'h00;
      chk("a_occupancy", 64'(a_occ), 64'(q.size()));
      chk("b_occupancy", 64'(b_occ), 64'(q.size()));
      chk("a_out_valid", 64'(a_out_valid), 64'(v));
      chk("b_out_valid", 64'(b_out_valid), 64'(v));
      chk("a_in_ready", 64'(a_in_ready), 64'(q.size() < 2));
      chk("b_in_ready", 64'(b_in_ready), 64'(q.size() < 2));
      chk("a_ctrl", 64'(a_ctrl), 64'(ec));
      chk("b_ctrl", 64'(b_ctrl), 64'(ec));
      chk("a_funct", 64'(a_funct), 64'(last.funct));
      chk("b_funct", 64'(b_funct), 64'(last.funct));
      chk("a_rs1", 64'(a_rs1), 64'(last.rs1[4:0]));
      chk("a_rs2", 64'(a_rs2), 64'(last.rs2[4:0]));
      chk("a_rd", 64'(a_rd), 64'(last.rd[4:0]));
      chk("b_rs1", 64'(b_rs1), 64'(last.rs1));
      chk("b_rs2", 64'(b_rs2), 64'(last.rs2));
      chk("b_rd", 64'(b_rd), 64'(last.rd));
      chk("a_imm", a_imm, last.imm);
      chk("a_rd1", a_rd1, last.rd1);
      chk("a_rd2", a_rd2, last.rd2);
      chk("a_pc", a_pc, last.pc);
      chk("b_imm", 64'(b_imm), 64'(last.imm[31:0]));
      chk("b_rd1", 64'(b_rd1), 64'(last.rd1[31:0]));
      chk("b_rd2", 64'(b_rd2), 64'(last.rd2[31:0]));
      chk("b_pc", 64'(b_pc), 64'(last.pc[31:0]));
   endtask

   // One clock: predict transfers from the model, advance it, then check.
   task automatic cycle(output bit pushed);
      bit push, pop;
      push = in_valid && (q.size() < 2);
      pop  = out_ready && (q.size() > 0);
      @(posedge clk);
      pushed = 1'b0;
      if (reset) begin
         q.delete();
         last = '0;
      end else if (flush) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (push) begin
            q.push_back(in_p);
            pushed = 1'b1;
         end
      end
      if (q.size() > 0) last = q[0];
      #1;
      check_outputs();
   endtask

   vec_t vecs[17];

   initial begin
      bit pushed;
      int sent;
      int cyc;
      pay_t nxt;

      // {rst, fl, iv, ordy, pc, ctrl, exp_occ, exp_ov, exp_ir, exp_pc}
      vecs[0]  = '{1, 0, 0, 0, 64'h0,   8'h00, 0, 0, 1, 64'h0};
      vecs[1]  = '{0, 0, 1, 1, 64'h100, 8'h5A, 1, 1, 1, 64'h100};
      vecs[2]  = '{0, 0, 0, 1, 64'h0,   8'h00, 0, 0, 1, 64'h0};
      vecs[3]  = '{0, 0, 1, 0, 64'h10,  8'h11, 1, 1, 1, 64'h10};
      vecs[4]  = '{0, 0, 1, 0, 64'h20,  8'h22, 2, 1, 0, 64'h10};
      vecs[5]  = '{0, 0, 1, 0, 64'h30,  8'h33, 2, 1, 0, 64'h10};
      vecs[6]  = '{0, 0, 0, 1, 64'h30,  8'h33, 1, 1, 1, 64'h20};
      vecs[7]  = '{0, 0, 0, 1, 64'h0,   8'h00, 0, 0, 1, 64'h0};
      vecs[8]  = '{0, 0, 1, 0, 64'h40,  8'h44, 1, 1, 1, 64'h40};
      vecs[9]  = '{0, 0, 1, 0, 64'h50,  8'h55, 2, 1, 0, 64'h40};
      vecs[10] = '{0, 1, 1, 1, 64'h60,  8'h66, 0, 0, 1, 64'h0};
      vecs[11] = '{0, 0, 1, 0, 64'h70,  8'hFF, 1, 1, 1, 64'h70};
      vecs[12] = '{1, 1, 1, 1, 64'h80,  8'hFF, 0, 0, 1, 64'h0};
      vecs[13] = '{0, 0, 0, 1, 64'h0,   8'h00, 0, 0, 1, 64'h0};
      vecs[14] = '{0, 0, 1, 0, 64'h90,  8'h99, 1, 1, 1, 64'h90};
      vecs[15] = '{0, 0, 1, 0, 64'hA0,  8'hAA, 2, 1, 0, 64'h90};
      vecs[16] = '{1, 0, 0, 1, 64'h0,   8'h00, 0, 0, 1, 64'h0};

      @(negedge clk);
      for (int i = 0; i < 17; i++) begin
         nxt      = rand_pay();
         nxt.pc   = vecs[i].pc;
         nxt.ctrl = vecs[i].ctrl;
         reset     = vecs[i].rst;
         flush     = vecs[i].fl;
         in_valid  = vecs[i].iv;
         out_ready = vecs[i].ordy;
         in_p      = nxt;
         cycle(pushed);
         chk($sformatf("v%0d_occ", i), 64'(a_occ), 64'(vecs[i].eocc));
         chk($sformatf("v%0d_ov", i), 64'(a_out_valid), 64'(vecs[i].eov));
         chk($sformatf("v%0d_ir", i), 64'(a_in_ready), 64'(vecs[i].eir));
         chk($sformatf("v%0d_b_occ", i), 64'(b_occ), 64'(vecs[i].eocc));
         if (vecs[i].eov) begin
            chk($sformatf("v%0d_pc", i), a_pc, vecs[i].epc);
            chk($sformatf("v%0d_b_pc", i), 64'(b_pc), 64'(vecs[i].epc[31:0]));
         end else begin
            chk($sformatf("v%0d_ctrl", i), 64'(a_ctrl), 64'h0);
         end
         if (vecs[i].rst) begin
            chk($sformatf("v%0d_rst_imm", i), a_imm, 64'h0);
            chk($sformatf("v%0d_rst_rd", i), 64'(a_rd), 64'h0);
         end
         @(negedge clk);
      end
      reset = 1'b0;
      flush = 1'b0;

      // Random stream of 100 payloads with random handshakes.
      sent = 0;
      cyc  = 0;
      nxt  = rand_pay();
      while ((sent < 100 || q.size() > 0) && cyc < 3000) begin
         in_valid  = (sent < 100) && ($urandom_range(0, 99) < 60);
         out_ready = ($urandom_range(0, 99) < 55);
         in_p      = nxt;
         cycle(pushed);
         if (pushed) begin
            sent++;
            nxt = rand_pay();
         end
         cyc++;
         @(negedge clk);
      end
      tests++;
      if (cyc >= 3000) begin
         failed++;
         $display("FAIL stream_timeout: got %0d sent, queue %0d, required 100 sent and drained", sent, q.size());
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/id_ex_pipe_reg.md
ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning width of immediate, read data and PC fields.
REQ-002 The block SHALL have parameter REG_W, default 5, meaning width of the rs1/rs2/rd fields.
REQ-003 The block SHALL have parameter CTRL_W, default 8, meaning width of the packed control bundle (ALU_Op[1:0], Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite from bit 7 down to bit 0).
REQ-004 The block SHALL have parameter FUNCT_W, default 4, meaning width of the funct field.
REQ-005 The block SHALL have ports clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have ports reset, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have ports flush, input, 1, synchronous discard of all held entries.
REQ-008 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1), the upstream handshake.
REQ-009 The block SHALL have ports in_ctrl (input, CTRL_W), in_funct (input, FUNCT_W), in_rs1/in_rs2/in_rd (input, REG_W each), in_imm/in_rd1/in_rd2/in_pc (input, DATA_W each), the payload.
REQ-010 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1), the downstream handshake.
REQ-011 The block SHALL have ports out_ctrl, out_funct, out_rs1, out_rs2, out_rd, out_imm, out_rd1, out_rd2, out_pc (outputs, widths matching inputs), the registered payload.
REQ-012 The block SHALL have port occupancy, output, 2, number of valid entries held (0..2).

Function
REQ-013 The block SHALL hold up to two entries: main (drives out_*) and skid.
REQ-014 The block SHALL implement states EMPTY (occ 0), ONE (main valid), TWO (main and skid valid); occupancy SHALL equal the state count.
REQ-015 in_ready SHALL equal NOT skid-valid, registered, with no combinational path from out_ready.
REQ-016 An upstream transfer SHALL occur when in_valid and in_ready are both 1 at a rising edge; a downstream transfer when out_valid and out_ready are both 1.
REQ-017 EMPTY + transfer in -> ONE; payload loaded into main; out_valid 1 the next cycle (latency 1).
REQ-018 ONE, transfer in and out in the same cycle -> ONE; main takes the new payload.
REQ-019 ONE, transfer in only -> TWO; payload loaded into skid; main unchanged.
REQ-020 ONE, transfer out only -> EMPTY.
REQ-021 TWO, transfer out -> ONE; skid moves into main; in_ready returns to 1 the next cycle.
REQ-022 TWO, no transfer out -> hold; no input accepted because in_ready is 0.
REQ-023 Order SHALL be preserved; no entry is dropped or duplicated.
REQ-024 flush=1 at an edge -> EMPTY regardless of in/out handshakes that cycle; the input offered that cycle is discarded; flush SHALL take priority over every transfer.
REQ-025 out_ctrl SHALL be all-zero whenever out_valid=0 (bubble = NOP); other out_* fields hold their last value when not valid.
REQ-026 out_* SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 No arithmetic on payload; fields SHALL pass bit-exact at the parameter widths.

Reset
REQ-028 reset=1 at an edge SHALL force EMPTY, out_valid 0, in_ready 1, occupancy 0, and all out_* fields 0.
REQ-029 reset SHALL take priority over flush and all transfers, including mid-operation in TWO.
REQ-030 The block SHALL produce no output transfer in the cycle after reset deasserts until an input transfer occurs.

Verification
REQ-031 Reset, then in_valid=1 with pc=0x100 and out_ready=1 for 1 cycle -> next cycle out_valid=1, out_pc=0x100, occupancy=1.
REQ-032 out_ready=0; push pc=0x10, then 0x20 -> occupancy=2, in_ready=0; a third offer pc=0x30 is not accepted; raise out_ready -> outputs 0x10, then 0x20, then occupancy=0.
REQ-033 TWO state, flush=1 with in_valid=1 and out_ready=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0x00, in_ready=1.
REQ-034 Stream of 100 payloads with random in_valid/out_ready, flush low -> output sequence identical to input, in order, none lost.
REQ-035 In ONE with ctrl=0xFF, reset=1 together with flush=1 and in_valid=1 -> next cycle all outputs 0, occupancy=0.
REQ-036 Parameter set DATA_W=32, REG_W=6 -> repeat REQ-031 and REQ-032 with bit-exact field widths.
